// File: rtl/dmem_access_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: request/write payload in,
// grant and read-return out. One instance per requester.
interface dmem_access_arbiter_if #(
    parameter int unsigned DATA_W = 64
);
    logic              req;
    logic              we;
    logic [63:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_access_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the MEM stage
// (p0) and the loader/debug port (p1); one multi-cycle transaction in flight.
module dmem_access_arbiter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_access_arbiter_if.slave p0,
    dmem_access_arbiter_if.slave p1,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_wdata,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 addr_err,
    output logic                 busy
);
    localparam int unsigned PADDR_W = 64;
    localparam int unsigned CNT_W   = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT} state_t;

    state_t             state;
    logic               rr_ptr;   // 1: p1 wins a simultaneous request
    logic               owner;
    logic               lat_we;
    logic               lat_ok;
    logic [CNT_W-1:0]   cnt;

    logic               gnt0;
    logic               gnt1;
    logic               sel_we;
    logic [PADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_ok;
    logic               complete;
    logic [DATA_W-1:0]  cap_data;

    // Grant is combinational so the requester sees it in its request cycle
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == IDLE) begin
            gnt1 = p1.req && (!p0.req || rr_ptr);
            gnt0 = p0.req && !gnt1;
        end
    end

    assign p0.gnt = gnt0;
    assign p1.gnt = gnt1;
    assign busy   = (state != IDLE);

    always_comb begin
        sel_we    = gnt1 ? p1.we    : p0.we;
        sel_addr  = gnt1 ? p1.addr  : p0.addr;
        sel_wdata = gnt1 ? p1.wdata : p0.wdata;
        sel_ok    = (sel_addr[PADDR_W-1:ADDR_W] == '0);
    end

    // A read finishes either from memory or short-circuited by a range error
    always_comb begin
        complete = 1'b0;
        cap_data = '0;
        if (state == ACCESS && !lat_we && !lat_ok) begin
            complete = 1'b1;
        end else if (state == RDWAIT && cnt == CNT_W'(1)) begin
            complete = 1'b1;
            cap_data = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            lat_we    <= 1'b0;
            lat_ok    <= 1'b0;
            cnt       <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            addr_err  <= 1'b0;
            p0.rvalid <= 1'b0;
            p1.rvalid <= 1'b0;
            p0.rdata  <= '0;
            p1.rdata  <= '0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            addr_err  <= 1'b0;
            p0.rvalid <= 1'b0;
            p1.rvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner     <= gnt1;
                        rr_ptr    <= !gnt1;
                        lat_we    <= sel_we;
                        lat_ok    <= sel_ok;
                        mem_addr  <= sel_addr[ADDR_W-1:0];
                        mem_wdata <= sel_wdata;
                        mem_write <= sel_we && sel_ok;
                        mem_read  <= !sel_we && sel_ok;
                        addr_err  <= !sel_ok;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!lat_we && lat_ok) begin
                        cnt   <= CNT_W'(RD_LAT);
                        state <= RDWAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                RDWAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (complete) begin
                if (owner) begin
                    p1.rdata  <= cap_data;
                    p1.rvalid <= 1'b1;
                end else begin
                    p0.rdata  <= cap_data;
                    p0.rvalid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Scoreboard bench for dmem_access_arbiter: random traffic on both ports against
// a transaction-level model of arbitration, memory contents and response timing.
module tb_dmem_access_arbiter;
    localparam int unsigned RD_LAT = 3;
    localparam int K_RD  = 1;
    localparam int K_WR  = 2;
    localparam int K_ERR = 3;

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [63:0] data;
        int          due;
    } mexp_t;

    typedef struct {
        int          port;
        logic [63:0] data;
        int          due;
    } rexp_t;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        addr_err;
    logic        busy;

    dmem_access_arbiter_if #(.DATA_W(64)) p0_if ();
    dmem_access_arbiter_if #(.DATA_W(64)) p1_if ();

    dmem_access_arbiter #(.DATA_W(64), .ADDR_W(8), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0        (p0_if),
        .p1        (p1_if),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .addr_err  (addr_err),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    logic [63:0] ref_mem [256];
    int          ptr        = 0;
    int          busy_until = -1;
    logic [63:0] last_rd [2];
    mexp_t       mq[$];
    rexp_t       rq[$];

    // Memory with RD_LAT-deep read pipeline; junk data outside the valid slot
    logic [63:0]       mem [256];
    logic [63:0]       pipe_d [RD_LAT];
    logic [RD_LAT-1:0] pipe_v = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        pipe_v[0] <= mem_read;
        pipe_d[0] <= mem[mem_addr];
        for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign mem_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 64'hBADC_0FFE_E0DD_F00D;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w, input logic [63:0] a, input logic [63:0] d);
        if (p == 0) begin
            p0_if.req = r; p0_if.we = w; p0_if.addr = a; p0_if.wdata = d;
        end else begin
            p1_if.req = r; p1_if.we = w; p1_if.addr = a; p1_if.wdata = d;
        end
    endtask

    // Call just after a rising edge; returns just after the edge following the grant
    task automatic issue(input int p, input logic w, input logic [63:0] a, input logic [63:0] d);
        bit got = 1'b0;
        drive(p, 1'b1, w, a, d);
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            got = (p == 0) ? p0_if.gnt : p1_if.gnt;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout port=%0d actual=no_grant required=grant", p);
        end
        @(posedge clk);
        #1;
        drive(p, 1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic rand_txn(input int p);
        logic        w;
        logic [63:0] a;
        logic [63:0] d;
        w = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) a = {32'($urandom), 32'($urandom)} | 64'h100;
        else                           a = 64'($urandom_range(0, 15));
        d = {32'($urandom), 32'($urandom)};
        issue(p, w, a, d);
    endtask

    // Arbitration, busy and transaction bookkeeping
    always @(negedge clk) begin : grant_mon
        int          ep;
        logic        w;
        logic [63:0] a;
        logic [63:0] d;
        logic        ok;
        if (rst_n) begin
            check64("busy", 64'(busy), 64'(cyc <= busy_until));
            if (cyc <= busy_until)               ep = -1;
            else if (p0_if.req && p1_if.req)     ep = ptr;
            else if (p0_if.req)                  ep = 0;
            else if (p1_if.req)                  ep = 1;
            else                                 ep = -1;
            if (p0_if.req || p1_if.req || p0_if.gnt || p1_if.gnt)
                check64("grant", 64'({p1_if.gnt, p0_if.gnt}),
                        64'((ep == 0) ? 2'b01 : (ep == 1) ? 2'b10 : 2'b00));
            if (ep >= 0) begin
                w  = (ep == 1) ? p1_if.we    : p0_if.we;
                a  = (ep == 1) ? p1_if.addr  : p0_if.addr;
                d  = (ep == 1) ? p1_if.wdata : p0_if.wdata;
                ok = (a < 64'd256);
                ptr = 1 - ep;
                mq.push_back('{kind: !ok ? K_ERR : (w ? K_WR : K_RD), addr: a[7:0], data: d, due: cyc + 1});
                if (w) begin
                    if (ok) ref_mem[a[7:0]] = d;
                    busy_until = cyc + 1;
                end else begin
                    rq.push_back('{port: ep, data: ok ? ref_mem[a[7:0]] : 64'd0,
                                   due: cyc + (ok ? 2 + int'(RD_LAT) : 2)});
                    busy_until = cyc + (ok ? 1 + int'(RD_LAT) : 1);
                end
            end
        end
    end

    always @(negedge clk) begin : mem_mon
        mexp_t e;
        if (rst_n) begin
            if (mq.size() != 0 && mq[0].due <= cyc) begin
                e = mq.pop_front();
                check64("mem_strobes rd/wr/err", 64'({mem_read, mem_write, addr_err}),
                        64'({e.kind == K_RD, e.kind == K_WR, e.kind == K_ERR}));
                if (e.kind != K_ERR) check64("mem_addr", 64'(mem_addr), 64'(e.addr));
                if (e.kind == K_WR)  check64("mem_wdata", mem_wdata, e.data);
            end else if (mem_read || mem_write || addr_err) begin
                check64("mem_unexpected rd/wr/err", 64'({mem_read, mem_write, addr_err}), 64'd0);
            end
        end
    end

    always @(negedge clk) begin : rv_mon
        rexp_t e;
        if (rst_n) begin
            if (p0_if.rvalid || p1_if.rvalid) begin
                if (rq.size() == 0) begin
                    check64("rvalid_unexpected", 64'({p1_if.rvalid, p0_if.rvalid}), 64'd0);
                end else begin
                    e = rq.pop_front();
                    check64("rvalid_port", 64'({p1_if.rvalid, p0_if.rvalid}), 64'((e.port == 1) ? 2'b10 : 2'b01));
                    check64("rvalid_cycle", 64'(cyc), 64'(e.due));
                    check64("rdata", (e.port == 1) ? p1_if.rdata : p0_if.rdata, e.data);
                    last_rd[e.port] = e.data;
                end
            end else if (rq.size() != 0 && rq[0].due < cyc) begin
                e = rq.pop_front();
                check64("rvalid_missing", 64'd0, 64'd1);
            end
            check64("p0_rdata_hold", p0_if.rdata, last_rd[0]);
            check64("p1_rdata_hold", p1_if.rdata, last_rd[1]);
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 64'd0;
            ref_mem[i] = 64'd0;
        end
        last_rd[0] = 64'd0;
        last_rd[1] = 64'd0;
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check64("reset_mem_strobes", 64'({mem_read, mem_write, addr_err}), 64'd0);
        check64("reset_busy", 64'(busy), 64'd0);
        check64("reset_mem_addr", 64'(mem_addr), 64'd0);
        check64("reset_mem_wdata", mem_wdata, 64'd0);
        check64("reset_rvalid", 64'({p1_if.rvalid, p0_if.rvalid}), 64'd0);
        check64("reset_p0_rdata", p0_if.rdata, 64'd0);
        check64("reset_p1_rdata", p1_if.rdata, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write then read back on p0
        issue(0, 1'b1, 64'h10, 64'hDEAD_BEEF);
        issue(0, 1'b0, 64'h10, 64'd0);

        // Both ports requesting back-to-back
        fork
            begin repeat (4) rand_txn(0); end
            begin repeat (4) rand_txn(1); end
        join

        // Same-address write by p0 racing a read by p1
        fork
            issue(0, 1'b1, 64'h20, 64'h55);
            issue(1, 1'b0, 64'h20, 64'd0);
        join

        // Out-of-range read and write
        issue(0, 1'b0, 64'h100, 64'd0);
        issue(0, 1'b1, 64'h100, 64'h1234);
        issue(1, 1'b0, 64'h8000_0000_0000_0010, 64'd0);

        fork
            begin repeat (150) begin rand_txn(0); repeat ($urandom_range(0, 3)) @(posedge clk); #1; end end
            begin repeat (150) begin rand_txn(1); repeat ($urandom_range(0, 3)) @(posedge clk); #1; end end
        join
        repeat (RD_LAT + 6) @(posedge clk);
        #1;

        // Reset in the middle of a read wait
        issue(0, 1'b0, 64'h10, 64'd0);
        @(posedge clk);
        #1;
        check64("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check64("rst_mem_strobes", 64'({mem_read, mem_write, addr_err}), 64'd0);
        check64("rst_busy", 64'(busy), 64'd0);
        check64("rst_rvalid", 64'({p1_if.rvalid, p0_if.rvalid}), 64'd0);
        check64("rst_p0_rdata", p0_if.rdata, 64'd0);
        mq.delete();
        rq.delete();
        ptr        = 0;
        busy_until = -1;
        last_rd[0] = 64'd0;
        last_rd[1] = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;

        // Simultaneous request after reset must favour p0
        fork
            issue(0, 1'b0, 64'h10, 64'd0);
            issue(1, 1'b0, 64'h20, 64'd0);
        join
        repeat (RD_LAT + 8) @(posedge clk);
        #1;
        check64("pending_reads_left", 64'(rq.size()), 64'd0);
        check64("pending_mem_ops_left", 64'(mq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_access_arbiter.md
Name: dmem_access_arbiter

Overview:
- Shares the single-port 256x64 data memory between two requesters: port 0 (pipeline MEM stage) and port 1 (program/data loader and debug).
- Arbitrates between the two ports and sequences each access as a multi-cycle transaction.
- Drives the memory's read/write strobes, address and write data, and returns read data to the requester that owns the transaction.
- Sits between the MEM-stage control and the data memory. Port 0 uses the pipeline's 64-bit ALU-result address directly.

Parameters:
- DATA_W, 64, data width of memory words and ports.
- ADDR_W, 8, memory index width (memory depth is 2**ADDR_W words).
- RD_LAT, 1, memory read latency in cycles from mem_read to valid mem_rdata; legal range 1..4.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- p0_req  in  1  port 0 request.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  64  port 0 address (ALU result).
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  port 0 grant pulse.
- p0_rvalid  out  1  port 0 read-data-valid pulse.
- p0_rdata  out  DATA_W  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory index.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- addr_err  out  1  out-of-range pulse.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: all outputs are 0, state is IDLE, the round-robin pointer favours port 0, and p0_rdata/p1_rdata are cleared to 0.
- Reset asserted mid-transaction abandons the transaction immediately. mem_read/mem_write drop asynchronously, no rvalid is issued, and no write completes after reset.
- States are IDLE, ACCESS, RDWAIT.
- IDLE:
  - If any req is high, grant one port with a combinational pN_gnt pulse in that same cycle.
  - Latch that port's we/addr/wdata/owner at the clock edge and go to ACCESS.
  - If both ports request, grant the port indicated by the pointer. After each grant, the pointer moves to the other port.
  - A lone request is always granted, regardless of the pointer.
- Requester protocol: hold req/we/addr/wdata stable until gnt, and drop or change them in the cycle after gnt. A req still high after gnt is a new request.
- ACCESS (exactly one cycle):
  - mem_addr = latched addr[ADDR_W-1:0]. mem_wdata = latched wdata.
  - For a write: mem_write=1, then go to IDLE.
  - For a read: mem_read=1, latency counter := RD_LAT, then go to RDWAIT.
- RDWAIT:
  - Decrement the counter each cycle.
  - In the cycle where the counter reaches 1, mem_rdata is valid. Capture it into the owner's rdata register at that edge and go to IDLE.
  - Assert the owner's rvalid for exactly one cycle, the cycle after capture; this coincides with IDLE, and a new grant may occur in the same cycle.
- Out-of-range address (any of bits 63:ADDR_W nonzero):
  - No memory access: mem_read/mem_write stay 0 in ACCESS.
  - addr_err pulses for one cycle in ACCESS.
  - A write is dropped and the state goes to IDLE.
  - A read skips RDWAIT: the owner's rdata := 0 and rvalid pulses the next cycle.
- pN_rdata holds its value until that port's next read completes. The other port's completions never modify it.
- Timing, grant at cycle T: write → mem_write at T+1, next grant possible at T+2. Read → mem_read at T+1, mem_rdata sampled at the end of T+1+RD_LAT, rvalid at T+2+RD_LAT.
- At most one transaction is in flight. gnt is never asserted while busy=1, and gnt is never asserted to both ports in the same cycle.

Test Plan:
- Reset then p0 write addr 0x10 data 0xDEAD_BEEF → p0_gnt at T, mem_write=1 with mem_addr=0x10 at T+1. Then p0 read 0x10 (RD_LAT=1) → p0_rvalid=1, p0_rdata=0xDEAD_BEEF at read-grant+3.
- p0 and p1 both request continuously from reset → grants alternate p0, p1, p0, p1; never both; busy between grants.
- p1 read 0x20 pending while p0 writes 0x20=0x55 (p0 granted first) → p1_rdata=0x55; p0_rdata unchanged, p0_rvalid stays 0.
- p0 read with p0_addr=0x100 → addr_err pulse, mem_read stays 0, p0_rvalid next cycle with p0_rdata=0. Write to 0x100 → addr_err, no mem_write.
- RD_LAT=3 read → mem_read at T+1, p0_rvalid exactly at T+5; no earlier capture.
- rst_n low in RDWAIT → mem_read/mem_write low immediately, no rvalid, state IDLE. After release, p0 is favoured on a simultaneous request.
